// File: rtl/boa_mem_pkg.sv
// Shared types and parameter legality helpers for the Boa memory bus arbiter.
// Functions are constant-evaluable so they can size ports and gate elaboration checks.
package boa_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic bit alen_legal(input int a);
        return a >= 8;
    endfunction

    function automatic bit dlen_legal(input int d);
        return (d == 32) || (d == 64);
    endfunction

    function automatic bit ports_legal(input int p);
        return (p >= 1) && (p <= 8);
    endfunction

    function automatic int idx_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

    function automatic int wait_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/boa_rr_picker.sv
// Combinational round-robin picker: first pending requester after 'last', wrapping.
// Scans {pending, pending-above-last}; the lowest set bit is the winner.
module boa_rr_picker
    import boa_mem_pkg::*;
#(
    parameter int ports = 2,
    localparam int IW = idx_width(ports)
) (
    input  logic [ports-1:0] i_pending,
    input  logic [IW-1:0]    i_last,
    output logic [ports-1:0] o_grant,
    output logic [IW-1:0]    o_idx,
    output logic             o_valid
);

    logic [ports-1:0]   w_above;
    logic [2*ports-1:0] w_scan;

    always_comb begin
        w_above = '0;
        for (int i = 0; i < ports; i++) begin
            w_above[i] = (i > int'(i_last));
        end
    end

    assign w_scan = {i_pending, i_pending & w_above};

    // Walk downwards so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 2*ports-1; k >= 0; k--) begin
            if (w_scan[k]) begin
                o_valid = 1'b1;
                o_idx   = IW'(k % ports);
            end
        end
    end

    assign o_grant = o_valid ? (ports'(1) << o_idx) : '0;

endmodule

// File: rtl/boa_mem_arbiter.sv
// N-to-1 round-robin arbiter for the Boa memory bus with byte strobes and a
// response timeout that completes the transfer with an error instead of hanging.
module boa_mem_arbiter
    import boa_mem_pkg::*;
#(
    parameter int alen    = 32,
    parameter int dlen    = 32,
    parameter int ports   = 2,
    parameter int timeout = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ports-1:0]                 req_re,
    input  logic [ports-1:0][dlen/8-1:0]     req_we,
    input  logic [ports-1:0][alen-3:0]       req_addr,
    input  logic [ports-1:0][dlen-1:0]       req_wdata,
    output logic [ports-1:0]                 req_ready,
    output logic [ports-1:0]                 req_err,
    output logic [dlen-1:0]                  req_rdata,
    output logic                             mem_re,
    output logic [dlen/8-1:0]                mem_we,
    output logic [alen-3:0]                  mem_addr,
    output logic [dlen-1:0]                  mem_wdata,
    input  logic                             mem_ready,
    input  logic [dlen-1:0]                  mem_rdata
);

    localparam int IW = idx_width(ports);
    localparam int CW = wait_width(timeout);
    localparam logic [CW-1:0] TO_LAST = (timeout > 0) ? CW'(timeout - 1) : '0;

    if (!alen_legal(alen)) begin : g_bad_alen
        $fatal(1, "boa_mem_arbiter: alen must be at least 8");
    end
    if (!dlen_legal(dlen)) begin : g_bad_dlen
        $fatal(1, "boa_mem_arbiter: dlen must be 32 or 64");
    end
    if (!ports_legal(ports)) begin : g_bad_ports
        $fatal(1, "boa_mem_arbiter: ports must be 1..8");
    end

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [IW-1:0]    r_last;
    logic [IW-1:0]    r_owner;
    logic [ports-1:0] r_owner_oh;
    logic [CW-1:0]    r_wait;

    logic [ports-1:0] w_pending;
    logic [ports-1:0] w_grant;
    logic [IW-1:0]    w_grant_idx;
    logic             w_grant_valid;
    logic             w_timeout_hit;
    logic             w_done;

    always_comb begin
        for (int i = 0; i < ports; i++) begin
            w_pending[i] = req_re[i] | (|req_we[i]);
        end
    end

    boa_rr_picker #(
        .ports (ports)
    ) u_picker (
        .i_pending (w_pending),
        .i_last    (r_last),
        .o_grant   (w_grant),
        .o_idx     (w_grant_idx),
        .o_valid   (w_grant_valid)
    );

    assign w_timeout_hit = (timeout != 0) && (r_state == BUSY) && !mem_ready
                           && (r_wait == TO_LAST);
    assign w_done        = (r_state == BUSY) && (mem_ready || w_timeout_hit);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_next_state = BUSY;
            BUSY:    if (w_done)        w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Owner and 'last' only move on a grant; the wait counter saturates rather than wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last     <= IW'(ports - 1);
            r_owner    <= '0;
            r_owner_oh <= '0;
            r_wait     <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_grant_valid) begin
                r_owner    <= w_grant_idx;
                r_owner_oh <= w_grant;
                r_last     <= w_grant_idx;
                r_wait     <= '0;
            end else if (r_state == BUSY && !mem_ready && r_wait != '1) begin
                r_wait <= r_wait + CW'(1);
            end
        end
    end

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        req_ready = '0;
        req_err   = '0;
        req_rdata = mem_rdata;
        if (r_state == BUSY) begin
            mem_re    = req_re[r_owner];
            mem_we    = req_we[r_owner];
            mem_addr  = req_addr[r_owner];
            mem_wdata = req_wdata[r_owner];
            req_ready = r_owner_oh & {ports{w_done}};
            req_err   = r_owner_oh & {ports{w_timeout_hit}};
            if (w_timeout_hit) begin
                req_rdata = '0;
            end
        end
    end

endmodule

// File: tb/tb_boa_mem_arbiter.sv
// Directed self-checking bench for boa_mem_arbiter with four ports and a 5-cycle timeout.
module tb_boa_mem_arbiter;

    localparam int A  = 32;
    localparam int D  = 32;
    localparam int P  = 4;
    localparam int TO = 5;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [P-1:0]             req_re;
    logic [P-1:0][D/8-1:0]    req_we;
    logic [P-1:0][A-3:0]      req_addr;
    logic [P-1:0][D-1:0]      req_wdata;
    logic [P-1:0]             req_ready;
    logic [P-1:0]             req_err;
    logic [D-1:0]             req_rdata;
    logic                     mem_re;
    logic [D/8-1:0]           mem_we;
    logic [A-3:0]             mem_addr;
    logic [D-1:0]             mem_wdata;
    logic                     mem_ready;
    logic [D-1:0]             mem_rdata;

    int errors = 0;
    int checks = 0;

    boa_mem_arbiter #(
        .alen    (A),
        .dlen    (D),
        .ports   (P),
        .timeout (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_re    (req_re),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_re    = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        #1;
        checks++; if (mem_re !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_re: got %b expected 0", mem_re); end
        checks++; if (mem_we !== 4'h0) begin errors++; $display("[TB] FAIL reset_mem_we: got %h expected 0", mem_we); end
        checks++; if (mem_addr !== 30'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (req_err !== 4'h0) begin errors++; $display("[TB] FAIL reset_req_err: got %b expected 0000", req_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        req_re[0]   = 1'b1;
        req_addr[0] = 30'h40;
        #1;
        checks++; if (mem_re !== 1'b0) begin errors++; $display("[TB] FAIL read_idle_before_grant: got %b expected 0", mem_re); end
        for (int c = 1; c <= 2; c++) begin
            tick();
            #1;
            checks++; if (mem_re !== 1'b1 || mem_addr !== 30'h40) begin errors++; $display("[TB] FAIL read_busy_c%0d: got re=%b addr=%h expected re=1 addr=40", c, mem_re, mem_addr); end
            checks++; if (req_ready !== 4'h0) begin errors++; $display("[TB] FAIL read_wait_ready_c%0d: got %b expected 0000", c, req_ready); end
        end
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (mem_re !== 1'b1) begin errors++; $display("[TB] FAIL read_busy_c3: got %b expected 1", mem_re); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL read_ready: got %b expected 0001", req_ready); end
        checks++; if (req_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_rdata: got %h expected deadbeef", req_rdata); end
        checks++; if (req_err !== 4'h0) begin errors++; $display("[TB] FAIL read_err: got %b expected 0000", req_err); end
        tick();
        mem_ready = 1'b0;
        req_re[0] = 1'b0;
        #1;
        checks++; if (mem_re !== 1'b0 || req_ready !== 4'h0) begin errors++; $display("[TB] FAIL read_after_idle: got re=%b ready=%b expected 0 and 0000", mem_re, req_ready); end
    endtask

    task automatic test_byte_write();
        req_we[1]    = 4'b0100;
        req_wdata[1] = 32'h00AB0000;
        req_addr[1]  = 30'h10;
        tick();
        #1;
        checks++; if (mem_we !== 4'b0100) begin errors++; $display("[TB] FAIL write_mem_we: got %b expected 0100", mem_we); end
        checks++; if (mem_wdata !== 32'h00AB0000) begin errors++; $display("[TB] FAIL write_mem_wdata: got %h expected 00ab0000", mem_wdata); end
        checks++; if (mem_addr !== 30'h10 || mem_re !== 1'b0) begin errors++; $display("[TB] FAIL write_addr_re: got addr=%h re=%b expected 10 and 0", mem_addr, mem_re); end
        mem_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL write_ready: got %b expected 0010", req_ready); end
        tick();
        mem_ready = 1'b0;
        req_we[1] = '0;
        #1;
    endtask

    task automatic test_fairness();
        int exp_port[5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        req_re = 4'b1111;
        for (int i = 0; i < P; i++) begin
            req_addr[i] = 30'(i + 1);
        end
        mem_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (mem_re !== 1'b0) begin errors++; $display("[TB] FAIL fair_idle_%0d: got re=%b expected 0", k, mem_re); end
            tick();
            #1;
            checks++; if (mem_addr !== 30'(exp_port[k] + 1) || req_ready !== (4'b0001 << exp_port[k])) begin
                errors++;
                $display("[TB] FAIL fair_grant_%0d: got addr=%h ready=%b expected addr=%0d ready=%b", k, mem_addr, req_ready, exp_port[k] + 1, 4'b0001 << exp_port[k]);
            end
            tick();
            #1;
        end
        req_re    = '0;
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        req_re[2]   = 1'b1;
        req_addr[2] = 30'h77;
        mem_rdata   = 32'h12345678;
        for (int c = 1; c <= TO - 1; c++) begin
            tick();
            #1;
            checks++; if (mem_re !== 1'b1 || req_ready !== 4'h0) begin errors++; $display("[TB] FAIL to_wait_c%0d: got re=%b ready=%b expected 1 and 0000", c, mem_re, req_ready); end
        end
        tick();
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL to_ready: got %b expected 0100", req_ready); end
        checks++; if (req_err !== 4'b0100) begin errors++; $display("[TB] FAIL to_err: got %b expected 0100", req_err); end
        checks++; if (req_rdata !== 32'h0) begin errors++; $display("[TB] FAIL to_rdata: got %h expected 0", req_rdata); end
        tick();
        req_re[2] = 1'b0;
        #1;
        checks++; if (mem_re !== 1'b0 || req_err !== 4'h0) begin errors++; $display("[TB] FAIL to_back_idle: got re=%b err=%b expected 0 and 0000", mem_re, req_err); end
        tick();
        mem_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'h0 || req_err !== 4'h0) begin errors++; $display("[TB] FAIL to_late_ready: got ready=%b err=%b expected 0000", req_ready, req_err); end
        checks++; if (req_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL to_rdata_passthru: got %h expected 12345678", req_rdata); end
        tick();
        mem_ready = 1'b0;
        #1;
        checks++; if (mem_re !== 1'b0) begin errors++; $display("[TB] FAIL to_no_regrant: got %b expected 0", mem_re); end
    endtask

    task automatic test_reset_mid_transfer();
        req_re[3]   = 1'b1;
        req_addr[3] = 30'h33;
        req_addr[0] = 30'h05;
        tick();
        #1;
        checks++; if (mem_re !== 1'b1 || mem_addr !== 30'h33) begin errors++; $display("[TB] FAIL rst_mid_grant: got re=%b addr=%h expected 1 and 33", mem_re, mem_addr); end
        rst_n  = 1'b0;
        req_re = 4'b1001;
        tick();
        mem_ready = 1'b1;
        #1;
        checks++; if (mem_re !== 1'b0 || req_ready !== 4'h0) begin errors++; $display("[TB] FAIL rst_mid_abort: got re=%b ready=%b expected 0 and 0000", mem_re, req_ready); end
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        tick();
        #1;
        checks++; if (mem_re !== 1'b1 || mem_addr !== 30'h05) begin errors++; $display("[TB] FAIL rst_port0_first: got re=%b addr=%h expected 1 and 05", mem_re, mem_addr); end
        req_re = '0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_byte_write();
        test_fairness();
        test_timeout();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boa_mem_arbiter.md
# boa_mem_arbiter

Parametrised N-to-1 arbiter for the Boa memory bus: `ports` requester channels (CPU side) share one memory channel (MEM side) under round-robin arbitration. It extends the single-channel bus with byte write strobes and a response timeout that returns an error instead of hanging. It sits between the instruction fetch, data and debug masters and the shared SRAM or peripheral fabric.

## Interface
Parameters:
- `alen`, 32, address width; at least 8; addresses are word addresses `[alen-1:2]`.
- `dlen`, 32, data width; 32 or 64.
- `ports`, 2, number of requesters; 1..8.
- `timeout`, 0, cycles a grant may wait for `mem_ready` before erroring; 0 disables the timeout.

Ports:
- `clk` in 1: clock; all logic is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_re` in [ports]×1: per-requester read enable.
- `req_we` in [ports]×dlen/8: per-requester byte write strobes; any bit set means write.
- `req_addr` in [ports]×(alen-2): per-requester word address.
- `req_wdata` in [ports]×dlen: per-requester write data.
- `req_ready` out [ports]×1: transfer complete for that requester.
- `req_err` out [ports]×1: transfer terminated by timeout; valid only with `req_ready`.
- `req_rdata` out dlen: read data, broadcast to all requesters.
- `mem_re` out 1, `mem_we` out dlen/8, `mem_addr` out alen-2, `mem_wdata` out dlen: forwarded request.
- `mem_ready` in 1, `mem_rdata` in dlen: memory response.

## Operation
- A request is pending when `req_re[i]` is 1 or `req_we[i]` is nonzero. The requester holds all request signals stable until its `req_ready` pulses.
- Setting `re` and `we` together is illegal. The arbiter forwards both unchanged; it does not check for this.
- States:
  - IDLE: all `mem_*` outputs are 0.
  - BUSY: forwards the owner's request.
- IDLE→BUSY happens when any request is pending. The owner is the first pending index searching from `last+1` modulo `ports`. `last` is updated to the owner.
- BUSY:
  - `mem_*` equals the owner's request.
  - `req_ready[owner] = mem_ready`. Every other `req_ready` is 0.
  - `req_rdata = mem_rdata` at all times.
- BUSY→IDLE happens on a cycle with `mem_ready=1`. The owner sees the completion on that cycle.
- Timeout:
  - `wait_cnt` clears on grant and increments each BUSY cycle while `mem_ready=0`.
  - When `timeout≠0` and `wait_cnt == timeout-1` with `mem_ready=0`, the block pulses `req_ready[owner]` and `req_err[owner]` for one cycle, and `req_rdata` reads as 0.
  - The state returns to IDLE. A late `mem_ready` arriving in IDLE is ignored.
- Requester withdraws its request while BUSY: protocol violation. Behaviour is undefined, but the arbiter still completes on `mem_ready` or timeout.
- With `ports=1`, the arbiter degenerates to an IDLE/BUSY pass-through with one bubble per transfer.

## Timing
- Reset values:
  - state = IDLE; `last = ports-1`, so port 0 wins first; `wait_cnt = 0`.
  - All `req_ready`, `req_err` and `mem_*` outputs are 0.
- Reset asserted mid-transfer: next edge enters IDLE and drops `mem_*`. No `req_ready` is issued for the aborted transfer.
- Latency:
  - Request seen at edge N (IDLE) → `mem_*` valid during cycle N+1.
  - Completion is combinational from `mem_ready` to `req_ready` in the same cycle.
- Mandatory IDLE cycle after each completion, so a stale request is never regranted. Peak throughput is one transfer per 2 cycles plus memory latency.
- The timeout error pulse occurs during BUSY cycle `timeout` (1-based).
- Simultaneous requests on the IDLE cycle: round-robin order guarantees each pending port is granted within `ports` transfers.
- `wait_cnt` width is `$clog2(timeout+1)`, minimum 1. It saturates and never wraps.

## Structure
- `boa_mem_pkg` holds the `arb_state_t` enum (IDLE, BUSY) and the `alen`/`dlen` legality checks as elaboration-time asserts.
- One sub-module, `boa_rr_picker #(ports)`:
  - Inputs: pending mask and `last`.
  - Outputs: one-hot grant, its index, and a valid flag.
  - Purely combinational, using a double-width mask scan.
- The arbiter FSM, the counter and the output muxes live in `boa_mem_arbiter`.

## Test plan
- **Single read:** port 0 reads addr 0x40; memory answers `rdata=0xDEADBEEF` after 3 cycles → `mem_re` high for 3 cycles, `req_ready[0]` pulses with `req_rdata=0xDEADBEEF`, `req_err=0`.
- **Byte write:** port 1 sets `we=4'b0100`, `wdata=0x00AB0000` → `mem_we=4'b0100`, `mem_wdata=0x00AB0000`; no `req_ready[0]`.
- **Fairness:** all 4 ports request continuously after reset → grants are 0,1,2,3,0 with one IDLE cycle between each.
- **Timeout:** `timeout=5`, memory never ready → error pulse in BUSY cycle 5 with `req_ready=1`, `req_err=1`, `req_rdata=0`. A late `mem_ready` 2 cycles after that is ignored.
- **Reset mid-transfer:** `rst_n=0` while BUSY → next cycle `mem_re=0` and no `req_ready`. After release, port 0 is granted first.
